keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//  Behavioural-synthesizable 4x4 keypad emulator: the switch-matrix end of the scan interface.
//  Accepts key-press requests over a valid/ready handshake.
//  Closes the requested contact for a programmed hold time.
//  Returns column levels in response to the scanner's row drive.
//  Used in benches and FPGA self-test builds in place of the physical keypad.
// PARAMETERS
//  BOUNCE_CYCLES  64        clk_in cycles of contact chatter on press and on release (KEYPAD_EMU_BOUNCE_EN only)
//  GAP_CYCLES     16        quiet (released) cycles after release before the next request is accepted
//  LFSR_SEED      16'hACE1  non-zero reset value of the chatter LFSR
//  ACTIVE_LOW     0         1: rows/cols active-low (idle col = 4'hF); 0: active-high (idle col = 4'h0)
// PORTS
//  clk_in      in   1   clock
//  reset_btn   in   1   asynchronous, active-high reset
//  req_valid   in   1   press request present
//  req_ready   out  1   emulator can accept a request (high only in IDLE)
//  req_key     in   4   key code = row*4 + col, sampled on accept
//  req_hold    in   16  contact-closed cycles, sampled on accept; 0 is treated as 1
//  req_abort   in   1   force early release (BOUNCE_IN/HOLD -> release path)
//  keypad_row  in   4   row drive from scanner
//  keypad_col  out  4   column return to scanner
//  pressed     out  1   registered contact state (1 = closed)
//  done        out  1   one-cycle pulse when a press/release sequence completes
// BEHAVIOUR
//  Reset (async): state IDLE, contact=0, pressed=0, done=0, req_ready=1, LFSR=LFSR_SEED, counters 0.
//  Reset mid-sequence: contact opens immediately; keypad_col goes idle in the same cycle; no done pulse.
//  Accept: req_valid && req_ready at a rising edge; req_key/req_hold latched; req_ready drops next cycle.
//  States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
//   IDLE       -accept->    BOUNCE_IN (macro on) or HOLD (macro off).
//   BOUNCE_IN  contact = lfsr[0]; after BOUNCE_CYCLES -> HOLD; req_abort -> BOUNCE_OUT/GAP.
//   HOLD       contact=1 for exactly max(req_hold,1) cycles -> BOUNCE_OUT (on) / GAP (off);
//              req_abort -> same target next cycle.
//   BOUNCE_OUT contact = lfsr[0]; after BOUNCE_CYCLES -> GAP.
//   GAP        contact=0 for GAP_CYCLES (0 => 1 cycle); exit -> IDLE with done=1 for that one cycle.
//  pressed = registered contact; macro off: pressed rises on the edge after accept.
//  keypad_col is combinational from keypad_row and registered contact (models a passive switch).
//   The column c = key[1:0] is active iff contact && row r = key[3:2] is active; all other cols idle.
//   The result is independent of other driven rows; multiple active rows are legal.
//  req_abort in IDLE/BOUNCE_OUT/GAP is ignored; abort and timer expiry in the same cycle -> same target.
//  req_valid held during a sequence is not consumed until IDLE; no queueing.
//  Hold counter is 16-bit, counts down, no wrap: 16'hFFFF holds 65535 cycles.
//  LFSR advances every cycle outside reset, in all states.
// CONFIGURATION
//  KEYPAD_EMU_BOUNCE_EN defined:
//   - BOUNCE_IN/BOUNCE_OUT present.
//   - Contact chatters pseudo-randomly for BOUNCE_CYCLES on each edge.
//  Undefined:
//   - Bounce states and LFSR are removed.
//   - Contact edges are clean; sequence is IDLE->HOLD->GAP->IDLE.
// STRUCTURE
//  keypad_pkg: state enum, KEY_W=4, ROWS=4, COLS=4, key_row()/key_col() helpers, idle-level constant.
//   Shared with the scanner.
//  Sub-module keypad_bounce_lfsr: 16-bit Galois LFSR with taps x^16+x^14+x^13+x^11+1.
//   Seed parameter; enable input.
//   Instantiated only under KEYPAD_EMU_BOUNCE_EN.
// TESTING
//  1. Press and row drive (macro off, ACTIVE_LOW=0):
//     key=4'h6, hold=10; drive row=4'b0010 -> col=4'b0100 for 10 cycles.
//     Then GAP 16 cycles, done pulse, req_ready=1.
//  2. Wrong row: key=4'hF held; row=4'b0001 -> col=4'h0; row=4'b1000 -> col=4'b1000 same cycle.
//  3. hold=0: pressed high exactly 1 cycle; done 17 cycles after pressed falls (GAP_CYCLES=16).
//  4. Abort: key=4'h0, hold=1000, req_abort at hold cycle 5 -> pressed falls next cycle; done after GAP.
//  5. Reset in HOLD: reset_btn pulse -> col idle same cycle, pressed=0, req_ready=1, no done.
//  6. Macro on (BOUNCE_CYCLES=8): pressed toggles within the first 8 and last 8 cycles of the contact window.
//     pressed is stable 1 across the full hold.
//     Identical seed gives an identical chatter sequence across runs.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad geometry, emulator state enum and key/column helpers shared with the scanner
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } kp_state_e;

  // Key code layout is row*4 + col.
  function automatic logic [$clog2(ROWS)-1:0] key_row(input logic [KEY_W-1:0] key);
    return key[3:2];
  endfunction

  function automatic logic [$clog2(COLS)-1:0] key_col(input logic [KEY_W-1:0] key);
    return key[1:0];
  endfunction

  // Level an undriven column sits at: all ones for active-low wiring, all zeros otherwise.
  function automatic logic [COLS-1:0] col_idle(input bit active_low);
    return active_low ? {COLS{1'b1}} : {COLS{1'b0}};
  endfunction

endpackage

// File: rtl/keypad_bounce_lfsr.sv
// rtl/keypad_bounce_lfsr.sv - 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) supplying contact chatter
module keypad_bounce_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk_in,
  input  logic reset_btn,
  input  logic en_i,
  output logic bit_o
);

  // Right-shifting Galois form; the mask holds taps 16, 14, 13 and 11.
  localparam logic [15:0] TAPS = 16'hB400;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next-state: shift right and fold the feedback bit into the tap positions.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    end
  end

  // State register; reset reloads the seed so chatter repeats identically run to run.
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 keypad switch-matrix emulator; KEYPAD_EMU_BOUNCE_EN adds contact chatter
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16,
  parameter bit          ACTIVE_LOW = 1'b0
`ifdef KEYPAD_EMU_BOUNCE_EN
  ,
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
`endif
) (
  input  logic             clk_in,
  input  logic             reset_btn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  input  logic [15:0]      req_hold,
  input  logic             req_abort,
  input  logic [ROWS-1:0]  keypad_row,
  output logic [COLS-1:0]  keypad_col,
  output logic             pressed,
  output logic             done
);

  // Zero-length phases are stretched to one cycle so every timed state is visited.
  localparam logic [15:0] GAP_LEN = (GAP_CYCLES == 0) ? 16'd1 : 16'(GAP_CYCLES);
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [15:0] BOUNCE_LEN = (BOUNCE_CYCLES == 0) ? 16'd1 : 16'(BOUNCE_CYCLES);
`endif

  kp_state_e        state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             contact_q, contact_d;
  logic             done_q, done_d;
  logic [15:0]      hold_eff;
  logic [ROWS-1:0]  row_act;
  logic [COLS-1:0]  col_act;

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [15:0] hold_q, hold_d;
  logic        chatter;

  keypad_bounce_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_in   (clk_in),
    .reset_btn(reset_btn),
    .en_i     (1'b1),
    .bit_o    (chatter)
  );
`endif

  assign hold_eff  = (req_hold == 16'd0) ? 16'd1 : req_hold;
  assign req_ready = (state_q == ST_IDLE);
  assign pressed   = contact_q;
  assign done      = done_q;

  // Sequencer: each timed state loads cnt on entry and leaves when it reaches 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    done_d    = 1'b0;
    contact_d = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          key_d = req_key;
`ifdef KEYPAD_EMU_BOUNCE_EN
          hold_d  = hold_eff;
          state_d = ST_BOUNCE_IN;
          cnt_d   = BOUNCE_LEN;
`else
          state_d = ST_HOLD;
          cnt_d   = hold_eff;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_IN: begin
        if (req_abort) begin
          state_d = ST_BOUNCE_OUT;
          cnt_d   = BOUNCE_LEN;
        end else if (cnt_q <= 16'd1) begin
          state_d = ST_HOLD;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      ST_HOLD: begin
        if (req_abort || cnt_q <= 16'd1) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_d = ST_BOUNCE_OUT;
          cnt_d   = BOUNCE_LEN;
`else
          state_d = ST_GAP;
          cnt_d   = GAP_LEN;
`endif
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_OUT: begin
        if (cnt_q <= 16'd1) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LEN;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      ST_GAP: begin
        if (cnt_q <= 16'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    // Contact follows the state being entered so pressed lines up with the state register.
    contact_d = (state_d == ST_HOLD);
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (state_d == ST_BOUNCE_IN || state_d == ST_BOUNCE_OUT) begin
      contact_d = chatter;
    end
`endif
  end

  // State and contact registers; reset opens the contact at once, so the column idles immediately.
  always_ff @(posedge clk_in or posedge reset_btn) begin
    if (reset_btn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      key_q     <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      hold_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      contact_q <= contact_d;
      done_q    <= done_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
      hold_q    <= hold_d;
`endif
    end
  end

  // Passive switch: the key's column echoes its own row only while the contact is closed.
  always_comb begin
    row_act = keypad_row ^ col_idle(ACTIVE_LOW);
    col_act = '0;
    if (contact_q && row_act[key_row(key_q)]) begin
      col_act[key_col(key_q)] = 1'b1;
    end
    keypad_col = col_act ^ col_idle(ACTIVE_LOW);
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator with a schedule-queue model
module tb_keypad_emulator;

  localparam int          GAP     = 16;
  localparam bit          ACT_LOW = 1'b0;
  localparam logic [15:0] SEED    = 16'hACE1;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int          BNC     = 8;
`else
  localparam int          BNC     = 0;
`endif

  localparam int PH_IDLE = 0;
  localparam int PH_CI   = 1;
  localparam int PH_H    = 2;
  localparam int PH_CO   = 3;
  localparam int PH_G    = 4;

  logic        clk_in = 1'b0;
  logic        reset_btn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_key = 4'h0;
  logic [15:0] req_hold = 16'h0;
  logic        req_abort = 1'b0;
  logic [3:0]  keypad_row = 4'h0;
  logic [3:0]  keypad_col;
  logic        pressed;
  logic        done;

  int checks = 0;
  int failures = 0;

  keypad_emulator #(
    .GAP_CYCLES(GAP),
    .ACTIVE_LOW(ACT_LOW)
`ifdef KEYPAD_EMU_BOUNCE_EN
    ,
    .BOUNCE_CYCLES(BNC),
    .LFSR_SEED(SEED)
`endif
  ) dut (
    .clk_in    (clk_in),
    .reset_btn (reset_btn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_hold  (req_hold),
    .req_abort (req_abort),
    .keypad_row(keypad_row),
    .keypad_col(keypad_col),
    .pressed   (pressed),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on accept, the whole press is laid out as a queue of per-cycle phases.
  int          sched[$];
  logic [15:0] m_lfsr;
  logic        m_chat;
  logic [3:0]  m_key;
  logic        m_done;

  always @(posedge clk_in) begin
    int n;
    if (reset_btn) begin
      sched.delete();
      m_lfsr = SEED;
      m_chat = 1'b0;
      m_done = 1'b0;
      m_key  = 4'h0;
    end else begin
      m_chat = m_lfsr[0];
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      m_done = 1'b0;
      if (sched.size() == 0) begin
        if (req_valid) begin
          m_key = req_key;
          n = (req_hold == 16'd0) ? 1 : int'(req_hold);
          for (int j = 0; j < BNC; j++) sched.push_back(PH_CI);
          for (int j = 0; j < n; j++) sched.push_back(PH_H);
          for (int j = 0; j < BNC; j++) sched.push_back(PH_CO);
          for (int j = 0; j < ((GAP == 0) ? 1 : GAP); j++) sched.push_back(PH_G);
        end
      end else begin
        if (req_abort && (sched[0] == PH_CI || sched[0] == PH_H)) begin
          while (sched.size() > 0 && (sched[0] == PH_CI || sched[0] == PH_H)) void'(sched.pop_front());
        end else begin
          void'(sched.pop_front());
        end
        if (sched.size() == 0) m_done = 1'b1;
      end
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk_in) begin
    int         ph;
    logic       e_p;
    logic [3:0] ra;
    logic [3:0] e_col;
    ph  = (sched.size() > 0) ? sched[0] : PH_IDLE;
    e_p = (ph == PH_H) || ((ph == PH_CI || ph == PH_CO) && m_chat);
    ra  = ACT_LOW ? ~keypad_row : keypad_row;
    e_col = 4'h0;
    if (e_p && ra[m_key / 4]) e_col[m_key % 4] = 1'b1;
    if (ACT_LOW) e_col = ~e_col;
    check("m_pressed", 64'(pressed), 64'(e_p));
    check("m_ready", 64'(req_ready), 64'(sched.size() == 0));
    check("m_done", 64'(done), 64'(m_done));
    check("m_col", 64'(keypad_col), 64'(e_col));
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  // Issue one request and follow it to its done pulse, recording what a scanner would see.
  task automatic run_seq(input logic [3:0] key, input logic [15:0] hold, input logic [3:0] row,
                         input int abort_at, output int n_press, output int n_col,
                         output int n_fall, output logic rdy_at_done, output logic [63:0] tr);
    logic seen;
    logic got;
    n_press = 0;
    n_col = 0;
    n_fall = 0;
    rdy_at_done = 1'b0;
    tr = '0;
    seen = 1'b0;
    got = 1'b0;
    tick();
    req_key = key;
    req_hold = hold;
    keypad_row = row;
    req_valid = 1'b1;
    for (int i = 0; i < 70000 && !got; i++) begin
      @(negedge clk_in);
      if (i < 64) tr[i] = pressed;
      if (pressed) begin
        n_press++;
        seen = 1'b1;
      end else if (seen) begin
        n_fall++;
      end
      if (keypad_col != 4'h0) n_col++;
      if (done) begin
        got = 1'b1;
        rdy_at_done = req_ready;
      end
      #1;
      req_valid = 1'b0;
      req_abort = (abort_at > 0) && pressed && (n_press == abort_at);
    end
    req_valid = 1'b0;
    req_abort = 1'b0;
    check("seq_done_seen", 64'(got), 64'd1);
  endtask

`ifndef KEYPAD_EMU_BOUNCE_EN
  task automatic start_req(input logic [3:0] key, input logic [15:0] hold);
    tick();
    req_key = key;
    req_hold = hold;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk_in);
      if (done) got = 1'b1;
    end
    #1;
    check("wait_done", 64'(got), 64'd1);
  endtask
`else
  task automatic do_reset();
    tick();
    reset_btn = 1'b1;
    tick();
    reset_btn = 1'b0;
  endtask
`endif

  initial begin
    int np, nc, nf, dn;
    logic rd;
    logic [63:0] tr1, tr2;

    keypad_row = 4'hF;
    tick();
    tick();
    check("rst_pressed", 64'(pressed), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_col", 64'(keypad_col), 64'h0);
    reset_btn = 1'b0;

`ifndef KEYPAD_EMU_BOUNCE_EN
    // Key 6 = row 1, col 2.
    run_seq(4'h6, 16'd10, 4'b0010, 0, np, nc, nf, rd, tr1);
    check("t1_press_cycles", 64'(np), 64'd10);
    check("t1_col_cycles", 64'(nc), 64'd10);
    check("t1_fall_to_done", 64'(nf), 64'd17);
    check("t1_ready_at_done", 64'(rd), 64'd1);

    // Key F = row 3, col 3; other rows never reach its column.
    keypad_row = 4'b0000;
    start_req(4'hF, 16'd20);
    tick();
    tick();
    keypad_row = 4'b0001;
    #1 check("t2_wrong_row", 64'(keypad_col), 64'h0);
    keypad_row = 4'b1000;
    #1 check("t2_right_row", 64'(keypad_col), 64'h8);
    keypad_row = 4'b1001;
    #1 check("t2_multi_row", 64'(keypad_col), 64'h8);
    wait_done(60);

    run_seq(4'hA, 16'd0, 4'b0100, 0, np, nc, nf, rd, tr1);
    check("t3_press_cycles", 64'(np), 64'd1);
    check("t3_fall_to_done", 64'(nf), 64'd17);

    run_seq(4'h0, 16'd1000, 4'b0001, 5, np, nc, nf, rd, tr1);
    check("t4_press_cycles", 64'(np), 64'd5);
    check("t4_fall_to_done", 64'(nf), 64'd17);

    // Key 9 = row 2, col 1; reset lands mid-hold.
    keypad_row = 4'b0100;
    start_req(4'h9, 16'd50);
    tick();
    tick();
    check("t5_col_hold", 64'(keypad_col), 64'h2);
    reset_btn = 1'b1;
    #1;
    check("t5_rst_col", 64'(keypad_col), 64'h0);
    check("t5_rst_pressed", 64'(pressed), 64'd0);
    check("t5_rst_ready", 64'(req_ready), 64'd1);
    tick();
    reset_btn = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (done) dn++;
    end
    #1;
    check("t5_no_done", 64'(dn), 64'd0);

    // Held request: a new press starts only after each done, every 3 + 16 + 1 cycles.
    keypad_row = 4'b0010;
    req_key = 4'h5;
    req_hold = 16'd3;
    req_valid = 1'b1;
    dn = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_in);
      if (done) dn++;
    end
    #1;
    req_valid = 1'b0;
    check("t7_done_pulses", 64'(dn), 64'd2);
    wait_done(40);

    run_seq(4'h3, 16'hFFFF, 4'b0001, 0, np, nc, nf, rd, tr1);
    check("t8_press_ffff", 64'(np), 64'd65535);
`else
    do_reset();
    run_seq(4'h6, 16'd20, 4'b0010, 0, np, nc, nf, rd, tr1);
    check("b_in_chatter", 64'(tr1[7:0]), 64'h70);
    check("b_hold_stable", 64'(tr1[27:8]), 64'hFFFFF);
    check("b_ready_at_done", 64'(rd), 64'd1);
    do_reset();
    run_seq(4'h6, 16'd20, 4'b0010, 0, np, nc, nf, rd, tr2);
    check("b_repeat_seq", tr2, tr1);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
